// File: rtl/renode_pkg.sv
// rtl/renode_pkg.sv - shared types for the Renode bus arbiter slice
package renode_pkg;

  // Width of the response data holder; arbiter DataWidth must not exceed it.
  localparam int RSP_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } arb_state_e;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic                  error;
    logic                  timeout;
  } arb_rsp_t;

  // Index width for an N-entry one-hot vector, never below one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/renode_bus_arbiter_if.sv
// rtl/renode_bus_arbiter_if.sv - requester and bus-controller signals of the arbiter
interface renode_bus_arbiter_if #(
  parameter int RequestersCount = 2,
  parameter int AddressWidth    = 32,
  parameter int DataWidth       = 32
);
  logic [RequestersCount-1:0]              req_valid;
  logic [RequestersCount-1:0]              req_ready;
  logic [RequestersCount-1:0]              req_write;
  logic [RequestersCount*AddressWidth-1:0] req_addr;
  logic [RequestersCount*DataWidth-1:0]    req_wdata;
  logic [RequestersCount-1:0]              rsp_valid;
  logic [DataWidth-1:0]                    rsp_rdata;
  logic                                    rsp_error;
  logic                                    rsp_timeout;
  logic                                    bus_valid;
  logic                                    bus_ready;
  logic                                    bus_write;
  logic [AddressWidth-1:0]                 bus_addr;
  logic [DataWidth-1:0]                    bus_wdata;
  logic                                    bus_rsp_valid;
  logic [DataWidth-1:0]                    bus_rdata;
  logic                                    bus_error;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output bus_valid, bus_write, bus_addr, bus_wdata,
    input  bus_ready, bus_rsp_valid, bus_rdata, bus_error
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  bus_valid, bus_write, bus_addr, bus_wdata,
    output bus_ready, bus_rsp_valid, bus_rdata, bus_error
  );
endinterface

// File: rtl/renode_rr_picker.sv
// rtl/renode_rr_picker.sv - combinational round-robin pick starting after the pointer
module renode_rr_picker
  import renode_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan ptr+1, ptr+2, ... wrapping at N; the first requester found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/renode_bus_arbiter.sv
// rtl/renode_bus_arbiter.sv - round-robin single-outstanding bus arbiter (watchdog: RENODE_BUS_ARBITER_TIMEOUT_EN)
module renode_bus_arbiter
  import renode_pkg::*;
#(
  parameter  int RequestersCount = 2,
  parameter  int AddressWidth    = 32,
  parameter  int DataWidth       = 32,
  parameter  int TimeoutCycles   = 100,
  localparam int IW              = idx_width(RequestersCount)
) (
  input  logic                 clk,
  input  logic                 rst,
  renode_bus_arbiter_if.slave  bif,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
);

  localparam int N  = RequestersCount;
  localparam int AW = AddressWidth;
  localparam int DW = DataWidth;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic [N-1:0]  pick_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  arb_rsp_t      rsp_q;
  logic          timeout_hit;

  renode_rr_picker #(.N(N)) u_picker (
    .req   (bif.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef RENODE_BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles + 1);
  logic [CW-1:0] tmo_cnt_q;

  // Watchdog: held at zero outside a transaction, counts every ISSUE/WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ISSUE || state_q == WAIT) &&
                       (tmo_cnt_q == CW'(TimeoutCycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; bus completions only count while in WAIT.
  always_comb begin
    state_d       = state_q;
    bif.req_ready = '0;
    bif.bus_valid = 1'b0;
    bif.rsp_valid = '0;
    case (state_q)
      IDLE: begin
        bif.req_ready = pick_grant;
        if (pick_any) state_d = ISSUE;
      end
      ISSUE: begin
        bif.bus_valid = 1'b1;
        if (timeout_hit)        state_d = RESPOND;
        else if (bif.bus_ready) state_d = WAIT;
      end
      WAIT: begin
        if (timeout_hit || bif.bus_rsp_valid) state_d = RESPOND;
      end
      RESPOND: begin
        bif.rsp_valid[grant_id] = 1'b1;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch on accept and response latch on completion or watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= IW'(N - 1);
      grant_id <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsp_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            ptr_q    <= pick_idx;
            grant_id <= pick_idx;
            write_q  <= bif.req_write[pick_idx];
            addr_q   <= bif.req_addr[int'(pick_idx)*AW +: AW];
            wdata_q  <= bif.req_wdata[int'(pick_idx)*DW +: DW];
          end
        end
        ISSUE: begin
          if (timeout_hit) rsp_q <= '{data: '0, error: 1'b1, timeout: 1'b1};
        end
        WAIT: begin
          if (timeout_hit) begin
            rsp_q <= '{data: '0, error: 1'b1, timeout: 1'b1};
          end else if (bif.bus_rsp_valid) begin
            rsp_q <= '{data: (write_q || bif.bus_error) ? '0 : RSP_DATA_W'(bif.bus_rdata),
                       error: bif.bus_error, timeout: 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign bif.bus_write   = write_q;
  assign bif.bus_addr    = addr_q;
  assign bif.bus_wdata   = wdata_q;
  assign bif.rsp_rdata   = (state_q == RESPOND) ? rsp_q.data[DW-1:0] : '0;
  assign bif.rsp_error   = (state_q == RESPOND) && rsp_q.error;
  assign bif.rsp_timeout = (state_q == RESPOND) && rsp_q.timeout;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_renode_bus_arbiter.sv
// tb/tb_renode_bus_arbiter.sv - self-checking bench for renode_bus_arbiter
module tb_renode_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [0:0] grant_id;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        pend_v [N];
  logic        pend_w [N];
  logic [31:0] pend_a [N];
  logic [31:0] pend_d [N];
  int          last_g;

  always #5 clk = ~clk;

  renode_bus_arbiter_if #(.RequestersCount(N), .AddressWidth(AW), .DataWidth(DW)) bif ();

  renode_bus_arbiter #(
    .RequestersCount(N), .AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst), .bif(bif), .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Reference rule: the next owner is the first pending requester after the last owner.
  function automatic int model_pick();
    for (int i = 1; i <= N; i++) begin
      if (pend_v[(last_g + i) % N]) return (last_g + i) % N;
    end
    return -1;
  endfunction

  task automatic set_req();
    for (int i = 0; i < N; i++) begin
      bif.req_valid[i]          = pend_v[i];
      bif.req_write[i]          = pend_w[i];
      bif.req_addr[i*AW +: AW]  = pend_a[i];
      bif.req_wdata[i*DW +: DW] = pend_d[i];
    end
    #1;
  endtask

  task automatic new_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    pend_v[i] = 1'b1;
    pend_w[i] = w;
    pend_a[i] = a;
    pend_d[i] = d;
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    set_req();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst    = 1'b0;
    last_g = N - 1;
  endtask

  // One full transaction: accept, issue after rd stall cycles, complete sd cycles after handshake.
  task automatic txn(input int rd, input int sd, input logic [31:0] rdv, input logic err);
    int g;
    int t0;
    logic w;
    logic [31:0] a, d, exp_d;
    g = model_pick();
    set_req();
    if (g < 0) begin
      chk("txn_no_pending", 1, 0);
      return;
    end
    chk("req_ready_grant", bif.req_ready, onehot(g));
    chk("busy_idle", busy, 0);
    w = pend_w[g];
    a = pend_a[g];
    d = pend_d[g];
    pend_v[g] = 1'b0;
    last_g    = g;
    t0        = cyc;
    cycle();
    set_req();
    chk("grant_id", grant_id, g);
    chk("req_ready_busy", bif.req_ready, 0);
    for (int k = 0; k < rd; k++) begin
      chk("bus_valid_stall", bif.bus_valid, 1);
      cycle();
    end
    chk("bus_valid", bif.bus_valid, 1);
    chk("bus_write", bif.bus_write, w);
    chk("bus_addr", bif.bus_addr, a);
    chk("bus_wdata", bif.bus_wdata, d);
    bif.bus_ready = 1'b1;
    cycle();
    bif.bus_ready = 1'b0;
    chk("bus_valid_wait", bif.bus_valid, 0);
    for (int k = 0; k < sd; k++) begin
      chk("rsp_valid_wait", bif.rsp_valid, 0);
      cycle();
    end
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rdata     = rdv;
    bif.bus_error     = err;
    cycle();
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rdata     = '0;
    bif.bus_error     = 1'b0;
    exp_d = (w || err) ? 32'h0 : rdv;
    chk("rsp_valid", bif.rsp_valid, onehot(g));
    chk("rsp_rdata", bif.rsp_rdata, exp_d);
    chk("rsp_error", bif.rsp_error, err);
    chk("rsp_timeout", bif.rsp_timeout, 0);
    chk("latency", cyc - t0, 3 + rd + sd);
    cycle();
    chk("rsp_valid_pulse", bif.rsp_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int g;
    int t0;
    int hit;
    bif.bus_ready     = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rdata     = '0;
    bif.bus_error     = 1'b0;
    for (int i = 0; i < N; i++) new_req(i, 1'b0, 32'h0, 32'h0);
    clear_req();
    last_g = N - 1;
    cycle();
    cycle();

    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_bus_valid", bif.bus_valid, 0);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_req_ready", bif.req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_rsp_error", bif.rsp_error, 0);
    rst = 1'b0;

    // Zero-wait read by requester 0.
    new_req(0, 1'b0, 32'h1000, 32'h0);
    txn(0, 0, 32'hCAFE, 1'b0);

    // Both requesters held: grants alternate 0,1,0,1 from reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i]) new_req(i, 1'b0, 32'h100 * (i + 1) + k, 32'h0);
      txn(k % 2, 0, 32'h3000 + k, 1'b0);
      chk("rr_order", grant_id, k % 2);
    end
    clear_req();

    // Write with bus error.
    new_req(1, 1'b1, 32'h2000, 32'h55);
    txn(1, 1, 32'h1234, 1'b1);

    // Completion pulse while idle is ignored.
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rdata     = 32'hDEAD;
    cycle();
    bif.bus_rsp_valid = 1'b0;
    chk("idle_rsp_ignored", bif.rsp_valid, 0);
    chk("idle_busy", busy, 0);
    cycle();
    chk("idle_rsp_ignored2", bif.rsp_valid, 0);

`ifdef RENODE_BUS_ARBITER_TIMEOUT_EN
    // Controller never ready: watchdog answers TO cycles after ISSUE entry.
    new_req(0, 1'b0, 32'h4000, 32'h0);
    g = model_pick();
    set_req();
    chk("to_req_ready", bif.req_ready, onehot(g));
    pend_v[g] = 1'b0;
    last_g    = g;
    t0        = cyc;
    cycle();
    set_req();
    hit = -1;
    for (int k = 0; k < 20 && hit < 0; k++) begin
      if (bif.rsp_valid != 0) hit = cyc;
      else cycle();
    end
    chk("to_latency", hit - (t0 + 1), TO);
    chk("to_rsp_valid", bif.rsp_valid, onehot(g));
    chk("to_rsp_error", bif.rsp_error, 1);
    chk("to_rsp_timeout", bif.rsp_timeout, 1);
    chk("to_rsp_rdata", bif.rsp_rdata, 0);
    chk("to_bus_valid", bif.bus_valid, 0);
    cycle();
    bif.bus_rsp_valid = 1'b1;
    cycle();
    bif.bus_rsp_valid = 1'b0;
    chk("to_late_rsp", bif.rsp_valid, 0);
    chk("to_late_busy", busy, 0);
`endif

    // Reset while waiting for completion aborts silently.
    new_req(0, 1'b0, 32'h5000, 32'h0);
    g = model_pick();
    set_req();
    chk("ab_req_ready", bif.req_ready, onehot(g));
    pend_v[g] = 1'b0;
    cycle();
    set_req();
    bif.bus_ready = 1'b1;
    cycle();
    bif.bus_ready = 1'b0;
    chk("ab_busy_wait", busy, 1);
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    last_g = N - 1;
    chk("ab_busy", busy, 0);
    chk("ab_rsp_valid", bif.rsp_valid, 0);
    chk("ab_bus_valid", bif.bus_valid, 0);
    cycle();
    chk("ab_rsp_valid2", bif.rsp_valid, 0);
    new_req(1, 1'b0, 32'h6000, 32'h0);
    set_req();
    chk("ab_regrant", bif.req_ready, 2'b10);
    txn(0, 0, 32'h7777, 1'b0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && ($urandom % 2 == 1)) new_req(i, 1'($urandom % 2), $urandom, $urandom);
      end
      if (!pend_v[0] && !pend_v[1]) new_req(int'($urandom % 2), 1'($urandom % 2), $urandom, $urandom);
      txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom, ($urandom % 4) == 0);
    end
    clear_req();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
